alu_sequencer: RTL and testbench



---
 rtl/alu_sequencer.sv | 132 +++++++++++++
 tb/tb_alu_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Command-driven control sequencer for the register/mux/ALU datapath: runs
// setup / exec / write-back, optionally repeating as an accumulate loop.
module alu_sequencer #(
    parameter int unsigned SETUP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [3:0]  cmd_ra,
    input  logic [3:0]  cmd_rb,
    input  logic [3:0]  cmd_rd,
    input  logic [3:0]  cmd_rep,
    output logic [14:0] o_signal,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSetup = 3'd1,
        StExec  = 3'd2,
        StWrite = 3'd3,
        StDone  = 3'd4
    } state_e;

    localparam logic [1:0] SetupLast = 2'(SETUP_CYCLES - 1);

    state_e     state_q, state_d;
    logic [1:0] op_q, op_d;
    logic [3:0] ra_q, ra_d;
    logic [3:0] rb_q, rb_d;
    logic [3:0] rd_q, rd_d;
    logic [3:0] rep_cnt_q, rep_cnt_d;
    logic       acc_q, acc_d;
    logic [1:0] setup_cnt_q, setup_cnt_d;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        ra_d        = ra_q;
        rb_d        = rb_q;
        rd_d        = rd_q;
        rep_cnt_d   = rep_cnt_q;
        acc_d       = acc_q;
        setup_cnt_d = setup_cnt_q;
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    op_d        = cmd_op;
                    ra_d        = cmd_ra;
                    rb_d        = cmd_rb;
                    rd_d        = cmd_rd;
                    rep_cnt_d   = cmd_rep;
                    acc_d       = 1'b0;
                    setup_cnt_d = 2'd0;
                    state_d     = StSetup;
                end
            end
            StSetup: begin
                if (setup_cnt_q == SetupLast) begin
                    setup_cnt_d = 2'd0;
                    state_d     = StExec;
                end else begin
                    setup_cnt_d = setup_cnt_q + 2'd1;
                end
            end
            StExec: state_d = StWrite;
            StWrite: begin
                if (rep_cnt_q == 4'd0) begin
                    state_d = StDone;
                end else begin
                    // Later iterations feed the destination back as operand A.
                    rep_cnt_d = rep_cnt_q - 4'd1;
                    acc_d     = 1'b1;
                    state_d   = StExec;
                end
            end
            StDone: state_d = StIdle;
            default: begin
                state_d     = StIdle;
                rep_cnt_d   = 4'd0;
                acc_d       = 1'b0;
                setup_cnt_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            op_q        <= 2'd0;
            ra_q        <= 4'd0;
            rb_q        <= 4'd0;
            rd_q        <= 4'd0;
            rep_cnt_q   <= 4'd0;
            acc_q       <= 1'b0;
            setup_cnt_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            rd_q        <= rd_d;
            rep_cnt_q   <= rep_cnt_d;
            acc_q       <= acc_d;
            setup_cnt_q <= setup_cnt_d;
        end
    end

    // Decoded straight from state so an async reset clears w in the same cycle.
    always_comb begin
        o_signal  = 15'd0;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            StIdle: cmd_ready = 1'b1;
            StSetup, StExec, StWrite: begin
                busy     = 1'b1;
                o_signal = {op_q, (acc_q ? rd_q : ra_q), rb_q, rd_q, (state_q == StWrite)};
            end
            StDone: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: per-cycle expected {done, o_signal} words are
// queued at command issue and popped by a monitor while the sequencer is busy.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_valid4 = 1'b0;
    logic [1:0]  cmd_op = '0;
    logic [3:0]  cmd_ra = '0, cmd_rb = '0, cmd_rd = '0, cmd_rep = '0;
    logic        cmd_ready, busy, done;
    logic        cmd_ready4, busy4, done4;
    logic [14:0] o_signal, o_signal4;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp4_q[$];

    always #5 clk = ~clk;

    alu_sequencer #(.SETUP_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
        .cmd_rep(cmd_rep), .o_signal(o_signal), .busy(busy), .done(done)
    );

    alu_sequencer #(.SETUP_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4),
        .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
        .cmd_rep(cmd_rep), .o_signal(o_signal4), .busy(busy4), .done(done4)
    );

    // Monitors: every busy cycle must match the next queued word.
    always @(negedge clk) begin
        if (rst_n && busy) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL mon_extra_busy: got busy=1 sig=%h, required idle", o_signal);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if ({done, o_signal} !== e) begin
                    n_err++;
                    $display("FAIL mon_word t=%0t: got done,sig=%h required %h",
                             $time, {done, o_signal}, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && busy4) begin
            n_cmp++;
            if (exp4_q.size() == 0) begin
                n_err++;
                $display("FAIL mon4_extra_busy: got busy=1 sig=%h, required idle", o_signal4);
            end else begin
                logic [15:0] e;
                e = exp4_q.pop_front();
                if ({done4, o_signal4} !== e) begin
                    n_err++;
                    $display("FAIL mon4_word t=%0t: got done,sig=%h required %h",
                             $time, {done4, o_signal4}, e);
                end
            end
        end
    end

    // Reference timeline: S setup cycles, (rep+1) x {EXEC, WRITE}, then DONE.
    task automatic push_cmd(input bit sel4, input int s, input logic [1:0] op,
                            input logic [3:0] ra, input logic [3:0] rb,
                            input logic [3:0] rd, input logic [3:0] rep);
        logic [15:0] e;
        logic [3:0]  a;
        for (int c = 0; c < s; c++) begin
            e = {1'b0, op, ra, rb, rd, 1'b0};
            if (sel4) exp4_q.push_back(e); else exp_q.push_back(e);
        end
        for (int i = 0; i <= int'(rep); i++) begin
            a = (i == 0) ? ra : rd;
            e = {1'b0, op, a, rb, rd, 1'b0};
            if (sel4) exp4_q.push_back(e); else exp_q.push_back(e);
            e[0] = 1'b1;
            if (sel4) exp4_q.push_back(e); else exp_q.push_back(e);
        end
        e = 16'h8000;
        if (sel4) exp4_q.push_back(e); else exp_q.push_back(e);
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [3:0] rd, input logic [3:0] rep);
        @(negedge clk);
        cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd; cmd_rep = rep;
        cmd_valid = 1'b1;
        push_cmd(1'b0, 1, op, ra, rb, rd, rep);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input bit sel4, output int wcnt, output int dcnt, output bit tmo);
        wcnt = 0; dcnt = 0; tmo = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (sel4) begin
                wcnt += int'(o_signal4[0]); dcnt += int'(done4);
                if (exp4_q.size() == 0) begin tmo = 1'b0; break; end
            end else begin
                wcnt += int'(o_signal[0]); dcnt += int'(done);
                if (exp_q.size() == 0) begin tmo = 1'b0; break; end
            end
        end
    endtask

    task automatic test_reset;
        #1;
        n_cmp++;
        if ({o_signal, busy, done} !== 17'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got sig=%h busy=%b done=%b required 0", o_signal, busy, done);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        n_cmp++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || cmd_ready4 !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: got ready=%b busy=%b ready4=%b required 1 0 1",
                     cmd_ready, busy, cmd_ready4);
        end
    endtask

    task automatic check_drain(input string name, input int wexp, input bit sel4);
        int w, d; bit tmo;
        wait_drain(sel4, w, d, tmo);
        n_cmp++;
        if (tmo || w != wexp || d != 1) begin
            n_err++;
            $display("FAIL %s_counts: got timeout=%b w=%0d done=%0d required 0 %0d 1",
                     name, tmo, w, d, wexp);
        end
        @(negedge clk); #1;
        n_cmp++;
        if ((sel4 ? {cmd_ready4, busy4} : {cmd_ready, busy}) !== 2'b10) begin
            n_err++;
            $display("FAIL %s_idle: got ready,busy=%b required 10", name,
                     sel4 ? {cmd_ready4, busy4} : {cmd_ready, busy});
        end
    endtask

    task automatic test_single;
        issue(2'b01, 4'd3, 4'd5, 4'd7, 4'd0);
        check_drain("single", 1, 1'b0);
    endtask

    task automatic test_accumulate;
        issue(2'b00, 4'd1, 4'd2, 4'd4, 4'd2);
        check_drain("accumulate", 3, 1'b0);
        issue(2'b11, 4'd9, 4'd10, 4'd15, 4'd1);
        check_drain("accumulate_b", 2, 1'b0);
    endtask

    task automatic test_max_repeat;
        issue(2'b10, 4'd6, 4'd11, 4'd12, 4'd15);
        check_drain("max_repeat", 16, 1'b0);
        n_cmp++;
        if (dut.rep_cnt_q !== 4'd0) begin
            n_err++;
            $display("FAIL max_repeat_cnt: got rep_cnt=%0d required 0", dut.rep_cnt_q);
        end
    endtask

    // Valid held high with scrambled fields while busy; next command taken in IDLE.
    task automatic test_back_to_back;
        issue(2'b01, 4'd2, 4'd3, 4'd8, 4'd1);
        cmd_valid = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            cmd_op = 2'($urandom); cmd_ra = 4'($urandom); cmd_rb = 4'($urandom);
            cmd_rd = 4'($urandom); cmd_rep = 4'($urandom);
            #1;
            n_cmp++;
            if (cmd_ready !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_ready_busy c=%0d: got ready=%b required 0", c, cmd_ready);
            end
        end
        @(negedge clk);
        cmd_op = 2'b10; cmd_ra = 4'd13; cmd_rb = 4'd14; cmd_rd = 4'd1; cmd_rep = 4'd0;
        push_cmd(1'b0, 1, 2'b10, 4'd13, 4'd14, 4'd1, 4'd0);
        #1;
        n_cmp++;
        if ({cmd_ready, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL b2b_ready_idle: got ready,busy=%b required 10", {cmd_ready, busy});
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        check_drain("b2b_second", 1, 1'b0);
    endtask

    task automatic test_param;
        @(negedge clk);
        cmd_op = 2'b11; cmd_ra = 4'd5; cmd_rb = 4'd6; cmd_rd = 4'd9; cmd_rep = 4'd0;
        cmd_valid4 = 1'b1;
        push_cmd(1'b1, 4, 2'b11, 4'd5, 4'd6, 4'd9, 4'd0);
        @(posedge clk);
        #1 cmd_valid4 = 1'b0;
        check_drain("param_s4", 1, 1'b1);
    endtask

    task automatic test_reset_mid_write;
        issue(2'b01, 4'd3, 4'd4, 4'd5, 4'd1);
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (o_signal[0] !== 1'b1) begin
            n_err++;
            $display("FAIL rst_write_w: got w=%b required 1 in first WRITE", o_signal[0]);
        end
        #1 rst_n = 1'b0;
        #1;
        exp_q.delete();
        n_cmp++;
        if ({o_signal, busy, done} !== 17'd0) begin
            n_err++;
            $display("FAIL rst_mid_write: got sig=%h busy=%b done=%b required 0",
                     o_signal, busy, done);
        end
        repeat (2) begin
            @(negedge clk); #1;
            n_cmp++;
            if (o_signal !== 15'd0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL rst_hold: got sig=%h busy=%b required 0 0", o_signal, busy);
            end
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk); #1;
            n_cmp++;
            if ({cmd_ready, busy, o_signal} !== {2'b10, 15'd0}) begin
                n_err++;
                $display("FAIL rst_after: got ready=%b busy=%b sig=%h required 1 0 0",
                         cmd_ready, busy, o_signal);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_accumulate();
        test_max_repeat();
        test_back_to_back();
        test_param();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
